// File: rtl/regbank_wb_writer.sv
// rtl/regbank_wb_writer.sv - writeback queue feeding the register bank write port, with rs1/rs2 forwarding
module regbank_wb_writer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4:0]                   in_rd_addr,
  input  logic [XLEN-1:0]              in_data,
  output logic [4:0]                   rd_addr,
  output logic                         rd_we,
  output logic [XLEN-1:0]              rd_data_from_wb,
  input  logic [4:0]                   fwd_rs1_addr,
  input  logic [4:0]                   fwd_rs2_addr,
  output logic                         fwd_rs1_hit,
  output logic [XLEN-1:0]              fwd_rs1_data,
  output logic                         fwd_rs2_hit,
  output logic [XLEN-1:0]              fwd_rs2_data,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [4:0]      addr_q [DEPTH];
  logic [4:0]      addr_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            rd_we_q, rd_we_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            push, pop;

  assign in_ready        = (count_q < CW'(DEPTH));
  assign rd_we           = rd_we_q;
  assign rd_addr         = rd_addr_q;
  assign rd_data_from_wb = rd_data_q;
  assign pending         = count_q;
  assign idle            = (count_q == '0) && !rd_we_q;

  // Next-state: flush clears the queue; otherwise pop the head into the output register
  // every cycle the queue is non-empty and enqueue accepted non-x0 results at the tail.
  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rd_we_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      pop  = (count_q != '0);
      push = in_valid && in_ready && (in_rd_addr != 5'd0);
      if (pop) begin
        rd_we_d   = 1'b1;
        rd_addr_d = addr_q[head_q];
        rd_data_d = data_q[head_q];
        head_d    = head_q + PW'(1);
      end
      if (push) begin
        addr_d[tail_q] = in_rd_addr;
        data_d[tail_q] = in_data;
        tail_d         = tail_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control and output-register state, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Queue storage; contents only matter while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Forwarding: scan output register then queue oldest->youngest so the youngest match wins.
  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs2_data = '0;
    if (rd_we_q && fwd_rs1_addr != 5'd0 && rd_addr_q == fwd_rs1_addr) begin
      fwd_rs1_hit  = 1'b1;
      fwd_rs1_data = rd_data_q;
    end
    if (rd_we_q && fwd_rs2_addr != 5'd0 && rd_addr_q == fwd_rs2_addr) begin
      fwd_rs2_hit  = 1'b1;
      fwd_rs2_data = rd_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (fwd_rs1_addr != 5'd0 && addr_q[head_q + PW'(i)] == fwd_rs1_addr) begin
          fwd_rs1_hit  = 1'b1;
          fwd_rs1_data = data_q[head_q + PW'(i)];
        end
        if (fwd_rs2_addr != 5'd0 && addr_q[head_q + PW'(i)] == fwd_rs2_addr) begin
          fwd_rs2_hit  = 1'b1;
          fwd_rs2_data = data_q[head_q + PW'(i)];
        end
      end
    end
  end

endmodule
